// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the OTTER data-side memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    D_ISSUE = 3'd1,
    D_RESP  = 3'd2,
    IC_FILL = 3'd3,
    IC_LAST = 3'd4
  } arb_state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int unsigned LINE_WORDS_DEF = 8;

  // Latched CPU load/store command (address kept separately, it is parameterised)
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic [31:0] din;
  } d_cmd_t;

endpackage

// File: rtl/refill_seq.sv
// Burst word counter for cache line refills: issue index, returning-word index, last-issue flag.
module refill_seq #(
  parameter int unsigned LINE_WORDS = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          inc,
  output logic [$clog2(LINE_WORDS)-1:0] idx,
  output logic [$clog2(LINE_WORDS)-1:0] idx_dly,
  output logic                          last_issue
);

  localparam int unsigned IDX_W = $clog2(LINE_WORDS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx + IDX_W'(1);
    end
  end

  // Memory has one cycle of latency, so the word returning now is the previous issue
  assign idx_dly    = idx - IDX_W'(1);
  assign last_issue = (idx == IDX_W'(LINE_WORDS - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the OTTER memory data port between I-cache line refills and CPU loads/stores.
// Define ARB_FAIR_EN for round-robin arbitration; otherwise the data side has strict priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                          MEM_CLK,
  input  logic                          RST_N,
  input  logic                          IC_REQ,
  input  logic [ADDR_W-1:0]             IC_ADDR,
  output logic                          IC_GNT,
  output logic                          IC_WVALID,
  output logic [$clog2(LINE_WORDS)-1:0] IC_WIDX,
  output logic [31:0]                   IC_WDATA,
  output logic                          IC_DONE,
  input  logic                          D_REQ,
  input  logic                          D_WE,
  input  logic [ADDR_W-1:0]             D_ADDR,
  input  logic [31:0]                   D_DIN,
  input  logic [1:0]                    D_SIZE,
  output logic                          D_ACK,
  output logic [31:0]                   D_RDATA,
  output logic                          M_RDEN,
  output logic                          M_WE,
  output logic [ADDR_W-1:0]             M_ADDR,
  output logic [31:0]                   M_DIN,
  output logic [1:0]                    M_SIZE,
  input  logic [31:0]                   M_DOUT
);

  localparam int unsigned IDX_W = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W = IDX_W + 2;

  arb_state_e               state_q, state_d;
  d_cmd_t                   dcmd_q;
  logic [ADDR_W-1:0]        daddr_q;
  logic [ADDR_W-OFF_W-1:0]  line_q;
  logic                     take_d, take_ic, cnt_clr, cnt_inc;
  logic                     pick_ic, pick_d;
  logic [IDX_W-1:0]         cnt, cnt_dly;
  logic                     last_issue;
  logic                     unused_ic_off;

  assign unused_ic_off = ^IC_ADDR[OFF_W-1:0];

  refill_seq #(.LINE_WORDS(LINE_WORDS)) u_refill_seq (
    .clk        (MEM_CLK),
    .rst_n      (RST_N),
    .clr        (cnt_clr),
    .inc        (cnt_inc),
    .idx        (cnt),
    .idx_dly    (cnt_dly),
    .last_issue (last_issue)
  );

`ifdef ARB_FAIR_EN
  logic last_ic_q;

  // Round-robin: on a tie, the side that did not win last time goes first
  assign pick_ic = IC_REQ && (!D_REQ || !last_ic_q);

  always_ff @(posedge MEM_CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_ic_q <= 1'b0;
    end else if (take_ic) begin
      last_ic_q <= 1'b1;
    end else if (take_d) begin
      last_ic_q <= 1'b0;
    end
  end
`else
  assign pick_ic = IC_REQ && !D_REQ;
`endif

  assign pick_d = D_REQ && !pick_ic;

  always_ff @(posedge MEM_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Winner's request is captured at grant so the memory side sees stable values
  always_ff @(posedge MEM_CLK or negedge RST_N) begin
    if (!RST_N) begin
      dcmd_q  <= '0;
      daddr_q <= '0;
      line_q  <= '0;
    end else begin
      if (take_d) begin
        dcmd_q  <= '{we: D_WE, size: D_SIZE, din: D_DIN};
        daddr_q <= D_ADDR;
      end
      if (take_ic) begin
        line_q <= IC_ADDR[ADDR_W-1:OFF_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    take_d    = 1'b0;
    take_ic   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    IC_GNT    = 1'b0;
    IC_WVALID = 1'b0;
    IC_WIDX   = '0;
    IC_WDATA  = '0;
    IC_DONE   = 1'b0;
    D_ACK     = 1'b0;
    D_RDATA   = '0;
    M_RDEN    = 1'b0;
    M_WE      = 1'b0;
    M_ADDR    = '0;
    M_DIN     = '0;
    M_SIZE    = '0;
    case (state_q)
      IDLE: begin
        if (pick_ic) begin
          take_ic = 1'b1;
          cnt_clr = 1'b1;
          state_d = IC_FILL;
        end else if (pick_d) begin
          take_d  = 1'b1;
          state_d = D_ISSUE;
        end
      end
      D_ISSUE: begin
        M_ADDR  = daddr_q;
        M_DIN   = dcmd_q.din;
        M_SIZE  = dcmd_q.size;
        M_RDEN  = !dcmd_q.we;
        M_WE    = dcmd_q.we;
        state_d = D_RESP;
      end
      D_RESP: begin
        D_ACK   = 1'b1;
        D_RDATA = dcmd_q.we ? '0 : M_DOUT;
        state_d = IDLE;
      end
      IC_FILL: begin
        // Issue word cnt while word cnt-1 returns: one word per cycle, no bubbles
        IC_GNT    = 1'b1;
        M_RDEN    = 1'b1;
        M_SIZE    = SZ_WORD;
        M_ADDR    = {line_q, cnt, 2'b00};
        cnt_inc   = 1'b1;
        IC_WVALID = (cnt != '0);
        IC_WIDX   = cnt_dly;
        IC_WDATA  = (cnt != '0) ? M_DOUT : '0;
        if (last_issue) begin
          state_d = IC_LAST;
        end
      end
      IC_LAST: begin
        IC_GNT    = 1'b1;
        IC_WVALID = 1'b1;
        IC_WIDX   = IDX_W'(LINE_WORDS - 1);
        IC_WDATA  = M_DOUT;
        IC_DONE   = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter with a one-cycle-latency memory model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        MEM_CLK = 1'b0;
  logic        RST_N;
  logic        IC_REQ, D_REQ, D_WE;
  logic [31:0] IC_ADDR, D_ADDR, D_DIN, M_DOUT;
  logic [1:0]  D_SIZE;
  logic        IC_GNT, IC_WVALID, IC_DONE, D_ACK, M_RDEN, M_WE;
  logic [2:0]  IC_WIDX;
  logic [31:0] IC_WDATA, D_RDATA, M_ADDR, M_DIN;
  logic [1:0]  M_SIZE;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter dut (
    .MEM_CLK(MEM_CLK), .RST_N(RST_N),
    .IC_REQ(IC_REQ), .IC_ADDR(IC_ADDR), .IC_GNT(IC_GNT), .IC_WVALID(IC_WVALID),
    .IC_WIDX(IC_WIDX), .IC_WDATA(IC_WDATA), .IC_DONE(IC_DONE),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_DIN(D_DIN), .D_SIZE(D_SIZE),
    .D_ACK(D_ACK), .D_RDATA(D_RDATA),
    .M_RDEN(M_RDEN), .M_WE(M_WE), .M_ADDR(M_ADDR), .M_DIN(M_DIN), .M_SIZE(M_SIZE),
    .M_DOUT(M_DOUT)
  );

  always #5 MEM_CLK = ~MEM_CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0104) return 32'hDEAD_BEEF;
    if (a >= 32'h40 && a <= 32'h5C) return 32'h100 + ((a - 32'h40) >> 2);
    return a ^ 32'hA5A5_0000;
  endfunction

  always @(posedge MEM_CLK) M_DOUT <= M_RDEN ? mem_word(M_ADDR) : 32'h0BAD_F00D;

  typedef struct {
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_din;
    logic [1:0]  d_size;
    logic        e_gnt, e_wv, e_done, e_ack, e_chk_rd, e_rden, e_we;
    logic [2:0]  e_widx;
    logic [1:0]  e_ms;
    logic [31:0] e_wd, e_rd, e_ma, e_md;
  } vec_t;

  vec_t vq[$];
  vec_t cin;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%h expected=%h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    logic [138:0] o;
    o = {IC_GNT, IC_WVALID, IC_WIDX, IC_WDATA, IC_DONE, D_ACK, D_RDATA,
         M_RDEN, M_WE, M_ADDR, M_DIN, M_SIZE};
    checks++;
    if (o !== '0) begin
      failures++;
      $display("FAIL %s actual_outputs=%h expected=0", nm, o);
    end
  endtask

  task automatic push(input logic gnt, input logic wv, input int widx, input logic [31:0] wd,
                      input logic done, input logic ack, input logic chk_rd, input logic [31:0] rd,
                      input logic rden, input logic we, input logic [31:0] ma,
                      input logic [31:0] md, input logic [1:0] ms);
    vec_t r;
    r = cin;
    r.e_gnt = gnt; r.e_wv = wv; r.e_widx = 3'(widx); r.e_wd = wd; r.e_done = done;
    r.e_ack = ack; r.e_chk_rd = chk_rd; r.e_rd = rd;
    r.e_rden = rden; r.e_we = we; r.e_ma = ma; r.e_md = md; r.e_ms = ms;
    vq.push_back(r);
  endtask

  task automatic push_idle();
    push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
  endtask

  // IDLE grant cycle, issue cycle, ack cycle; D_REQ left high for the caller to drop
  task automatic seq_data(input logic we, input logic [31:0] addr, input logic [31:0] din,
                          input logic [1:0] size);
    cin.d_req = 1'b1; cin.d_we = we; cin.d_addr = addr; cin.d_din = din; cin.d_size = size;
    push_idle();
    push(0, 0, 0, 0, 0, 0, 0, 0, !we, we, addr, din, size);
    push(0, 0, 0, 0, 0, 1, !we, mem_word(addr), 0, 0, 0, 0, 2'd0);
  endtask

  // IDLE grant cycle, 8 issue cycles, last-word cycle; D_REQ raised at issue index d_at
  task automatic seq_refill(input logic [31:0] ica, input int d_at);
    logic [31:0] line;
    int p;
    line = ica & ~32'h1F;
    cin.ic_req = 1'b1; cin.ic_addr = ica;
    push_idle();
    for (int k = 0; k < 8; k++) begin
      if (k == d_at) cin.d_req = 1'b1;
      p = (k + 7) % 8;
      push(1, k != 0, p, mem_word(line + 32'(4 * p)), 0, 0, 0, 0,
           1, 0, line + 32'(4 * k), 0, SZ_WORD);
    end
    push(1, 1, 7, mem_word(line + 32'd28), 1, 0, 0, 0, 0, 0, 0, 0, 2'd0);
  endtask

  task automatic drive(input vec_t v);
    IC_REQ = v.ic_req; IC_ADDR = v.ic_addr;
    D_REQ = v.d_req; D_WE = v.d_we; D_ADDR = v.d_addr; D_DIN = v.d_din; D_SIZE = v.d_size;
  endtask

  task automatic compare(input vec_t v, input int i);
    chk("gnt", i, IC_GNT, v.e_gnt);
    chk("wvalid", i, IC_WVALID, v.e_wv);
    chk("done", i, IC_DONE, v.e_done);
    chk("ack", i, D_ACK, v.e_ack);
    chk("rden", i, M_RDEN, v.e_rden);
    chk("we", i, M_WE, v.e_we);
    if (v.e_wv) begin
      chk("widx", i, IC_WIDX, v.e_widx);
      chk("wdata", i, IC_WDATA, v.e_wd);
    end
    if (v.e_ack && v.e_chk_rd) chk("rdata", i, D_RDATA, v.e_rd);
    if (v.e_rden || v.e_we) begin
      chk("maddr", i, M_ADDR, v.e_ma);
      chk("msize", i, M_SIZE, v.e_ms);
    end
    if (v.e_we) chk("mdin", i, M_DIN, v.e_md);
  endtask

  initial begin
    logic found;
    cin = '{default: '0};
    RST_N = 1'b0;
    drive(cin);

    push_idle();
    push_idle();
    // Load, store, byte load
    seq_data(1'b0, 32'h0000_0104, 32'h0, SZ_WORD);
    cin.d_req = 1'b0; push_idle();
    seq_data(1'b1, 32'h0000_0200, 32'h1234_5678, SZ_WORD);
    cin.d_req = 1'b0; push_idle();
    seq_data(1'b0, 32'h0000_0301, 32'h0, SZ_BYTE);
    cin.d_req = 1'b0; push_idle();
    // Plain refill of line 0x40
    seq_refill(32'h0000_0047, 99);
    cin.ic_req = 1'b0; push_idle();
    // Simultaneous requests, last grant was the refill
    cin.ic_req = 1'b1; cin.ic_addr = 32'h0000_0047;
    seq_data(1'b0, 32'h0000_0104, 32'h0, SZ_WORD);
`ifdef ARB_FAIR_EN
    seq_refill(32'h0000_0047, 0);
    cin.ic_req = 1'b0;
    seq_data(1'b0, 32'h0000_0104, 32'h0, SZ_WORD);
    cin.d_req = 1'b0; push_idle();
`else
    seq_data(1'b0, 32'h0000_0104, 32'h0, SZ_WORD);
    cin.d_req = 1'b0;
    seq_refill(32'h0000_0047, 99);
    cin.ic_req = 1'b0; push_idle();
`endif
    // Half-word store raised mid-refill waits for IC_DONE
    cin.d_we = 1'b1; cin.d_addr = 32'h0000_02C0; cin.d_din = 32'hCAFE_F00D; cin.d_size = SZ_HALF;
    seq_refill(32'h0000_1234, 3);
    cin.ic_req = 1'b0;
    seq_data(1'b1, 32'h0000_02C0, 32'hCAFE_F00D, SZ_HALF);
    cin.d_req = 1'b0; push_idle();

    repeat (3) @(negedge MEM_CLK);
    chk_zero("reset_state");
    RST_N = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge MEM_CLK); #1;
      drive(vq[i]);
      @(negedge MEM_CLK);
      compare(vq[i], i);
    end

    // Reset asserted mid-burst at word 3, then the line is refetched from word 0
    @(posedge MEM_CLK); #1;
    IC_REQ = 1'b1; IC_ADDR = 32'h0000_0047; D_REQ = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge MEM_CLK);
      if (IC_WVALID && IC_WIDX == 3'd3) found = 1'b1;
    end
    chk("rst_reach_word3", 0, found, 1);
    #2 RST_N = 1'b0;
    #1 chk_zero("rst_async_outputs");
    repeat (2) begin
      @(negedge MEM_CLK);
      chk_zero("rst_held_outputs");
    end
    RST_N = 1'b1;
    @(negedge MEM_CLK);
    chk("refetch_rden", 0, M_RDEN, 1);
    chk("refetch_addr0", 0, M_ADDR, 32'h40);
    chk("refetch_nowv", 0, IC_WVALID, 0);
    @(negedge MEM_CLK);
    chk("refetch_wv", 1, IC_WVALID, 1);
    chk("refetch_widx0", 1, IC_WIDX, 0);
    chk("refetch_word0", 1, IC_WDATA, 32'h100);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge MEM_CLK);
      if (IC_DONE) found = 1'b1;
    end
    chk("refetch_done_seen", 2, found, 1);
    chk("refetch_last_widx", 2, IC_WIDX, 7);
    chk("refetch_last_word", 2, IC_WDATA, 32'h107);
    @(posedge MEM_CLK); #1;
    IC_REQ = 1'b0;
    @(negedge MEM_CLK);
    chk("refetch_back_idle", 3, IC_GNT, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
